// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants for the round-robin decode arbiter: requester count, index width
// and the two-state FSM encoding.
package rr_decode_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_decode_arbiter_onehot_dec3to8.sv
// Purely combinational 3-to-8 one-hot decoder used to form the grant vector.
module onehot_dec3to8
    import rr_decode_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    // NOTE: default first, then override, so no path leaves onehot unassigned (no latch).
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with a per-tenure hold timer; the owner index
// is decoded to a one-hot grant that is registered one cycle behind the FSM state.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    logic             state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [NREQ-1:0]  idx_onehot;
    logic [IDX_W:0]   pick;
    logic             release_now;
    logic             force_now;

    // Scan ptr, ptr+1, ... with natural 3-bit wrap; iterating downward lets the
    // closest-to-ptr requester overwrite any later one. MSB of the result = found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = p + IDX_W'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    onehot_dec3to8 u_dec (
        .idx    (idx),
        .onehot (idx_onehot)
    );

    assign pick        = rr_pick(req, ptr);
    assign release_now = (state == ST_BUSY) && !req[idx];
    // A simultaneous drop of req wins over the timer, so timeout stays low then.
    assign force_now   = (state == ST_BUSY) && req[idx] &&
                         (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            idx         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
        end else begin
            grant       <= (state == ST_BUSY) ? idx_onehot : '0;
            grant_valid <= (state == ST_BUSY);
            timeout     <= force_now;
            if (state == ST_BUSY) grant_idx <= idx;

            case (state)
                ST_IDLE: begin
                    if (en && pick[IDX_W]) begin
                        idx      <= pick[IDX_W-1:0];
                        hold_cnt <= '0;
                        state    <= ST_BUSY;
                    end
                end
                default: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (release_now || force_now) begin
                        state <= ST_IDLE;
                        ptr   <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench: expected per-cycle outputs are queued as stimulus is applied and
// popped against the DUT on the falling edge after each rising edge.
module tb_rr_decode_arbiter;

    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic [2:0] i;
        logic       t;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       en, en4;
    logic [7:0] req, req4;
    logic [7:0] grant, grant4;
    logic       grant_valid, grant_valid4;
    logic [2:0] grant_idx, grant_idx4;
    logic       timeout, timeout4;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    rr_decode_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
    );

    rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .req(req4),
        .grant(grant4), .grant_valid(grant_valid4), .grant_idx(grant_idx4), .timeout(timeout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [7:0] g, input logic v,
                                input logic [2:0] i, input logic t);
        obs_t o;
        o.g = g; o.v = v; o.i = i; o.t = t;
        return o;
    endfunction

    task automatic push(input logic [7:0] g, input logic v, input logic [2:0] i, input logic t);
        sb.push_back(mk(g, v, i, t));
    endtask

    // n granted cycles ending in a forced release (timeout on the last one)
    task automatic push_tenure(input logic [7:0] g, input logic [2:0] i, input int n);
        for (int k = 0; k < n; k++) push(g, 1'b1, i, (k == n - 1));
    endtask

    task automatic check_now(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs g=%h v=%b i=%0d t=%b exp g=%h v=%b i=%0d t=%b",
                   tag, o.g, o.v, o.i, o.t, e.g, e.v, e.i, e.t);
        end
    endtask

    task automatic drain(input string tag, input bit sel4);
        obs_t e, o;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            o = sel4 ? mk(grant4, grant_valid4, grant_idx4, timeout4)
                     : mk(grant, grant_valid, grant_idx, timeout);
            check_now(tag, o, e);
        end
    endtask

    // Short reset pulse inside the low clock phase.
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; req = '0; en4 = 1'b0; req4 = '0;
        #1 rst = 1'b1;
        #2;
        check_now("reset16", mk(grant, grant_valid, grant_idx, timeout), mk(8'h00, 0, 0, 0));
        check_now("reset4", mk(grant4, grant_valid4, grant_idx4, timeout4), mk(8'h00, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // 1: single grant, two-edge latency, release one cycle later
        en = 1'b1; req = 8'h08;
        push(8'h00, 0, 0, 0);
        push(8'h08, 1, 3, 0);
        drain("t1_grant", 0);
        req = 8'h00;
        push(8'h08, 1, 3, 0);
        push(8'h00, 0, 3, 0);
        drain("t1_release", 0);

        // 2: two persistent requesters alternate, each force-released after 16 cycles
        pulse_rst();
        req = 8'h22;
        push(8'h00, 0, 0, 0);
        push_tenure(8'h02, 1, 16);
        push(8'h00, 0, 1, 0);
        push_tenure(8'h20, 5, 16);
        push(8'h00, 0, 5, 0);
        push_tenure(8'h02, 1, 16);
        drain("t2_rr_hold", 0);
        req = 8'h00;
        push(8'h00, 0, 1, 0);
        drain("t2_idle", 0);

        // 3: pointer wraps 7 -> 0 after owner 7 releases
        pulse_rst();
        req = 8'h80;
        push(8'h00, 0, 0, 0);
        push(8'h80, 1, 7, 0);
        drain("t3_own7", 0);
        req = 8'h01;
        push(8'h80, 1, 7, 0);
        drain("t3_rel7", 0);
        req = 8'h81;
        push(8'h00, 0, 7, 0);
        push(8'h01, 1, 0, 0);
        drain("t3_wrap", 0);
        req = 8'h00;
        push(8'h01, 1, 0, 0);
        push(8'h00, 0, 0, 0);
        drain("t3_idle", 0);

        // 4: MAX_HOLD=4 timeout, then a release coinciding with the timer limit
        en4 = 1'b1; req4 = 8'h04;
        push(8'h00, 0, 0, 0);
        push_tenure(8'h04, 2, 4);
        push(8'h00, 0, 2, 0);
        push(8'h04, 1, 2, 0);
        push(8'h04, 1, 2, 0);
        push(8'h04, 1, 2, 0);
        drain("t4_timeout", 1);
        req4 = 8'h00;
        push(8'h04, 1, 2, 0);
        push(8'h00, 0, 2, 0);
        drain("t4_simul", 1);
        en4 = 1'b0;

        // 5: async reset mid-tenure, then the scan restarts from 0
        req = 8'h10;
        push(8'h00, 0, 0, 0);
        push(8'h10, 1, 4, 0);
        drain("t5_own4", 0);
        req = 8'h11;
        #2 rst = 1'b1;
        #1;
        check_now("t5_async", mk(grant, grant_valid, grant_idx, timeout), mk(8'h00, 0, 0, 0));
        rst = 1'b0;
        push(8'h00, 0, 0, 0);
        push(8'h01, 1, 0, 0);
        drain("t5_restart", 0);
        req = 8'h00;
        push(8'h01, 1, 0, 0);
        push(8'h00, 0, 0, 0);
        drain("t5_idle", 0);

        // 6: en gates new grants only
        en = 1'b0; req = 8'hFF;
        push(8'h00, 0, 0, 0);
        push(8'h00, 0, 0, 0);
        push(8'h00, 0, 0, 0);
        drain("t6_en_off", 0);
        en = 1'b1;
        push(8'h00, 0, 0, 0);
        push(8'h02, 1, 1, 0);
        drain("t6_grant", 0);
        en = 1'b0;
        push(8'h02, 1, 1, 0);
        push(8'h02, 1, 1, 0);
        push(8'h02, 1, 1, 0);
        drain("t6_en_busy", 0);
        req = 8'h00;
        push(8'h02, 1, 1, 0);
        push(8'h00, 0, 1, 0);
        drain("t6_release", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
